// File: rtl/video_timing_gen_if.sv
// Video timing bundle: run/hold control into the generator, raster
// timing, coordinates and look-ahead fetch position out of it.
interface video_timing_gen_if #(
   parameter int H_BITS = 11,
   parameter int V_BITS = 10
);
   logic              enable;
   logic              active;
   logic              h_sync;
   logic              v_sync;
   logic              h_start;
   logic              v_start;
   logic              frame_end;
   logic [H_BITS-1:0] x;
   logic [V_BITS-1:0] y;
   logic              fetch_active;
   logic [H_BITS-1:0] fetch_x;
   logic [V_BITS-1:0] fetch_y;

   // The timing generator drives the raster and obeys enable
   modport master (
      input  enable,
      output active, h_sync, v_sync, h_start, v_start, frame_end,
      output x, y, fetch_active, fetch_x, fetch_y
   );

   // A downstream consumer controls enable and reads the raster
   modport slave (
      output enable,
      input  active, h_sync, v_sync, h_start, v_start, frame_end,
      input  x, y, fetch_active, fetch_x, fetch_y
   );
endinterface

// File: rtl/video_timing_gen.sv
// Raster timing generator for the HDMI/DVI output path. A main counter
// pair walks the full horizontal/vertical totals; a second pair runs LEAD
// clocks ahead to give upstream pipelines their fetch position. Every
// output is registered, so pins describe the previous clock's counters.
module video_timing_gen #(
   parameter int H_ACTIVE   = 1024,
   parameter int H_FRONT    = 48,
   parameter int H_SYNC     = 32,
   parameter int H_BACK     = 266,
   parameter int V_ACTIVE   = 600,
   parameter int V_FRONT    = 3,
   parameter int V_SYNC     = 6,
   parameter int V_BACK     = 21,
   parameter bit H_SYNC_POL = 1'b1,
   parameter bit V_SYNC_POL = 1'b1,
   parameter int LEAD       = 2
) (
   input logic                clk,
   input logic                reset_low,
   video_timing_gen_if.master vid
);
   localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
   localparam int H_BITS   = $clog2(H_TOTAL);
   localparam int V_BITS   = $clog2(V_TOTAL);
   localparam int HS_START = H_ACTIVE + H_FRONT;
   localparam int HS_END   = HS_START + H_SYNC;
   localparam int VS_START = V_ACTIVE + V_FRONT;
   localparam int VS_END   = VS_START + V_SYNC;

   localparam logic [H_BITS-1:0] H_LAST = H_BITS'(H_TOTAL - 1);
   localparam logic [V_BITS-1:0] V_LAST = V_BITS'(V_TOTAL - 1);
   localparam logic [H_BITS-1:0] LEAD_H = H_BITS'(LEAD);

   // Reject geometries that make no sense or a look-ahead past one line
   if (LEAD < 0 || LEAD >= H_TOTAL || H_ACTIVE == 0 || V_ACTIVE == 0 ||
       H_SYNC == 0 || V_SYNC == 0) begin : g_bad_params
      $error("video_timing_gen: illegal LEAD or zero active/sync width");
   end

   logic [H_BITS-1:0] h_idx;
   logic [V_BITS-1:0] v_idx;
   logic [H_BITS-1:0] f_h;
   logic [V_BITS-1:0] f_v;

   logic h_wrap;
   logic f_wrap;
   logic in_h;
   logic in_v;
   logic in_fh;
   logic in_fv;
   logic hs_on;
   logic vs_on;

   assign h_wrap = (h_idx == H_LAST);
   assign f_wrap = (f_h == H_LAST);

   // Region decode is done at 32 bits so region ends equal to the total
   // (zero back porch) still compare correctly
   assign in_h  = 32'(h_idx) < H_ACTIVE;
   assign in_v  = 32'(v_idx) < V_ACTIVE;
   assign in_fh = 32'(f_h) < H_ACTIVE;
   assign in_fv = 32'(f_v) < V_ACTIVE;
   assign hs_on = (32'(h_idx) >= HS_START) && (32'(h_idx) < HS_END);
   assign vs_on = (32'(v_idx) >= VS_START) && (32'(v_idx) < VS_END);

   // Main and look-ahead counters; disable parks both at the origin so the
   // restart is indistinguishable from a fresh reset release
   always_ff @(posedge clk or negedge reset_low) begin
      if (!reset_low) begin
         h_idx <= '0;
         v_idx <= '0;
         f_h   <= LEAD_H;
         f_v   <= '0;
      end else if (!vid.enable) begin
         h_idx <= '0;
         v_idx <= '0;
         f_h   <= LEAD_H;
         f_v   <= '0;
      end else begin
         h_idx <= h_wrap ? '0 : h_idx + 1'b1;
         if (h_wrap) begin
            v_idx <= (v_idx == V_LAST) ? '0 : v_idx + 1'b1;
         end
         f_h <= f_wrap ? '0 : f_h + 1'b1;
         if (f_wrap) begin
            f_v <= (f_v == V_LAST) ? '0 : f_v + 1'b1;
         end
      end
   end

   // Registered output stage: one clock behind the counters, idle while
   // in reset or disabled
   always_ff @(posedge clk or negedge reset_low) begin
      if (!reset_low) begin
         vid.active       <= 1'b0;
         vid.h_sync       <= !H_SYNC_POL;
         vid.v_sync       <= !V_SYNC_POL;
         vid.h_start      <= 1'b0;
         vid.v_start      <= 1'b0;
         vid.frame_end    <= 1'b0;
         vid.x            <= '0;
         vid.y            <= '0;
         vid.fetch_active <= 1'b0;
         vid.fetch_x      <= LEAD_H;
         vid.fetch_y      <= '0;
      end else if (!vid.enable) begin
         vid.active       <= 1'b0;
         vid.h_sync       <= !H_SYNC_POL;
         vid.v_sync       <= !V_SYNC_POL;
         vid.h_start      <= 1'b0;
         vid.v_start      <= 1'b0;
         vid.frame_end    <= 1'b0;
         vid.x            <= '0;
         vid.y            <= '0;
         vid.fetch_active <= 1'b0;
         vid.fetch_x      <= LEAD_H;
         vid.fetch_y      <= '0;
      end else begin
         vid.active       <= in_h && in_v;
         vid.h_sync       <= hs_on ? H_SYNC_POL : !H_SYNC_POL;
         vid.v_sync       <= vs_on ? V_SYNC_POL : !V_SYNC_POL;
         vid.h_start      <= (h_idx == '0) && in_v;
         vid.v_start      <= (h_idx == '0) && (v_idx == '0);
         vid.frame_end    <= h_wrap && (v_idx == V_LAST);
         vid.x            <= h_idx;
         vid.y            <= v_idx;
         vid.fetch_active <= in_fh && in_fv;
         vid.fetch_x      <= f_h;
         vid.fetch_y      <= f_v;
      end
   end
endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: a default-geometry instance (LEAD=3) driven
// through a table of hand-computed raster points, and a tiny-geometry
// instance with low-active syncs used for whole-frame corner cases.
module tb_video_timing_gen;
   logic clk;
   logic reset_low;

   int errors = 0;
   int checks = 0;
   int cycle  = 0;

   // line-0 statistics of the default instance and fetch relation tracking
   int  act_cnt   = 0;
   int  hs_cnt    = 0;
   int  fetch_bad = 0;
   bit  track_a   = 0;

   video_timing_gen_if #(.H_BITS(11), .V_BITS(10)) a_if ();
   video_timing_gen_if #(.H_BITS(4),  .V_BITS(3))  b_if ();

   video_timing_gen #(.LEAD(3)) dut_a (
      .clk       (clk),
      .reset_low (reset_low),
      .vid       (a_if.master)
   );

   video_timing_gen #(
      .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
      .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
      .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .LEAD(3)
   ) dut_b (
      .clk       (clk),
      .reset_low (reset_low),
      .vid       (b_if.master)
   );

   typedef struct {
      int k;
      int x;
      int y;
      int act;
      int hst;
      int vst;
      int hs;
      int fx;
      int fy;
      int fa;
   } vec_t;

   vec_t vecs[12];

   // Free-running pixel clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // One clock, sampled 1 time unit after the edge; collects line-0
   // statistics and the fetch-ahead relation of the default instance
   task automatic step();
      int p;
      @(posedge clk);
      #1;
      cycle++;
      if (track_a) begin
         if (cycle <= 1370) begin
            if (a_if.active) act_cnt++;
            if (a_if.h_sync) hs_cnt++;
         end
         p = (int'(a_if.y) * 1370 + int'(a_if.x) + 3) % 863100;
         if (int'(a_if.fetch_x) != p % 1370 || int'(a_if.fetch_y) != p / 1370)
            fetch_bad++;
      end
   endtask

   task automatic apply_stimulus(input vec_t v);
      while (cycle < v.k) step();
      check_output($sformatf("k%0d x", v.k), a_if.x, v.x);
      check_output($sformatf("k%0d y", v.k), a_if.y, v.y);
      check_output($sformatf("k%0d active", v.k), a_if.active, v.act);
      check_output($sformatf("k%0d h_start", v.k), a_if.h_start, v.hst);
      check_output($sformatf("k%0d v_start", v.k), a_if.v_start, v.vst);
      check_output($sformatf("k%0d h_sync", v.k), a_if.h_sync, v.hs);
      check_output($sformatf("k%0d fetch_x", v.k), a_if.fetch_x, v.fx);
      check_output($sformatf("k%0d fetch_y", v.k), a_if.fetch_y, v.fy);
      check_output($sformatf("k%0d fetch_active", v.k), a_if.fetch_active, v.fa);
   endtask

   task automatic check_idle_a(input string tag);
      check_output({tag, " a.active"}, a_if.active, 0);
      check_output({tag, " a.h_sync"}, a_if.h_sync, 0);
      check_output({tag, " a.v_sync"}, a_if.v_sync, 0);
      check_output({tag, " a.h_start"}, a_if.h_start, 0);
      check_output({tag, " a.v_start"}, a_if.v_start, 0);
      check_output({tag, " a.frame_end"}, a_if.frame_end, 0);
      check_output({tag, " a.x"}, a_if.x, 0);
      check_output({tag, " a.y"}, a_if.y, 0);
      check_output({tag, " a.fetch_x"}, a_if.fetch_x, 3);
      check_output({tag, " a.fetch_y"}, a_if.fetch_y, 0);
      check_output({tag, " a.fetch_active"}, a_if.fetch_active, 0);
   endtask

   task automatic do_reset();
      reset_low = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_idle_a("reset");
      check_output("reset b.h_sync", b_if.h_sync, 1);
      check_output("reset b.v_sync", b_if.v_sync, 1);
      check_output("reset b.fetch_x", b_if.fetch_x, 3);
      reset_low = 1'b1;
      cycle = 0;
   endtask

   int fe_q[$];
   int b_act, b_vs_low, b_hs_low, b_first_vs, b_first_hs, b_vs_x, b_vs_y;

   initial begin
      // k = cycle after reset release; the raster point shown is k-1
      vecs[0]  = '{1,    0,    0, 1, 1, 1, 0, 3,    0, 1};
      vecs[1]  = '{2,    1,    0, 1, 0, 0, 0, 4,    0, 1};
      vecs[2]  = '{1024, 1023, 0, 1, 0, 0, 0, 1026, 0, 0};
      vecs[3]  = '{1025, 1024, 0, 0, 0, 0, 0, 1027, 0, 0};
      vecs[4]  = '{1072, 1071, 0, 0, 0, 0, 0, 1074, 0, 0};
      vecs[5]  = '{1073, 1072, 0, 0, 0, 0, 1, 1075, 0, 0};
      vecs[6]  = '{1104, 1103, 0, 0, 0, 0, 1, 1106, 0, 0};
      vecs[7]  = '{1105, 1104, 0, 0, 0, 0, 0, 1107, 0, 0};
      vecs[8]  = '{1368, 1367, 0, 0, 0, 0, 0, 0,    1, 1};
      vecs[9]  = '{1371, 0,    1, 1, 1, 0, 0, 3,    1, 1};
      vecs[10] = '{8217, 1366, 5, 0, 0, 0, 0, 1369, 5, 0};
      vecs[11] = '{8219, 1368, 5, 0, 0, 0, 0, 1,    6, 1};

      reset_low   = 1'b0;
      a_if.enable = 1'b1;
      b_if.enable = 1'b1;

      // Default geometry: reset values, table of raster points, line stats
      do_reset();
      track_a = 1;
      for (int i = 0; i < 12; i++) apply_stimulus(vecs[i]);
      track_a = 0;
      check_output("line0 active clocks", act_cnt, 1024);
      check_output("line0 h_sync clocks", hs_cnt, 32);
      check_output("fetch_x/y lead errors", fetch_bad, 0);

      // Enable drop mid-line at x=500,y=6 for 4 clocks
      while (cycle < 6 * 1370 + 501) step();
      check_output("pre-drop x", a_if.x, 500);
      a_if.enable = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         check_idle_a($sformatf("disabled%0d", i));
      end
      a_if.enable = 1'b1;
      step();
      check_output("re-enable v_start", a_if.v_start, 1);
      check_output("re-enable h_start", a_if.h_start, 1);
      check_output("re-enable active", a_if.active, 1);
      check_output("re-enable x", a_if.x, 0);
      check_output("re-enable y", a_if.y, 0);
      check_output("re-enable fetch_x", a_if.fetch_x, 3);
      step();
      check_output("re-enable+1 x", a_if.x, 1);
      check_output("re-enable+1 v_start", a_if.v_start, 0);

      // Tiny geometry (16x8 totals, low-active syncs): three frames
      do_reset();
      b_act = 0; b_vs_low = 0; b_hs_low = 0; b_first_vs = 0; b_first_hs = 0;
      b_vs_x = -1; b_vs_y = -1;
      for (int i = 0; i < 384; i++) begin
         step();
         if (cycle <= 128) begin
            if (b_if.active) b_act++;
            if (!b_if.v_sync) begin
               b_vs_low++;
               if (b_first_vs == 0) begin
                  b_first_vs = cycle;
                  b_vs_x = int'(b_if.x);
                  b_vs_y = int'(b_if.y);
               end
            end
            if (!b_if.h_sync) begin
               b_hs_low++;
               if (b_first_hs == 0) b_first_hs = cycle;
            end
         end
         if (b_if.frame_end) fe_q.push_back(cycle);
         if (cycle == 126) begin
            check_output("b k126 fetch_x", b_if.fetch_x, 0);
            check_output("b k126 fetch_y", b_if.fetch_y, 0);
            check_output("b k126 fetch_active", b_if.fetch_active, 1);
         end
         if (cycle == 128) begin
            check_output("b k128 fetch_x", b_if.fetch_x, 2);
            check_output("b k128 fetch_y", b_if.fetch_y, 0);
            check_output("b k128 frame_end", b_if.frame_end, 1);
         end
      end
      check_output("b active clocks/frame", b_act, 32);
      check_output("b v_sync low clocks", b_vs_low, 32);
      check_output("b h_sync low clocks", b_hs_low, 24);
      check_output("b first v_sync low k", b_first_vs, 81);
      check_output("b first v_sync x", b_vs_x, 0);
      check_output("b first v_sync y", b_vs_y, 5);
      check_output("b first h_sync low k", b_first_hs, 11);
      check_output("b frame_end pulses", fe_q.size(), 3);
      if (fe_q.size() == 3) begin
         check_output("b frame_end first", fe_q[0], 128);
         check_output("b frame_end period1", fe_q[1] - fe_q[0], 128);
         check_output("b frame_end period2", fe_q[2] - fe_q[1], 128);
      end

      // Asynchronous reset between clock edges, mid-line
      check_output("pre-async a.x", a_if.x, 383);
      #3;
      reset_low = 1'b0;
      #1;
      check_idle_a("async");
      check_output("async b.h_sync", b_if.h_sync, 1);
      check_output("async b.v_sync", b_if.v_sync, 1);
      check_output("async b.x", b_if.x, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
